// File: rtl/id_decode_queue_if.sv
// rtl/id_decode_queue_if.sv - IF-to-ID instruction queue handshake/payload bundle
interface id_decode_queue_if #(
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             flush_i;
    logic             valid_i;
    logic             ready_o;
    logic [31:0]      instr_i;
    logic [63:0]      pc_i;
    logic             valid_o;
    logic             ready_i;
    logic [31:0]      instr_o;
    logic [63:0]      pc_o;
    logic [63:0]      imm_o;
    logic [CNT_W-1:0] occupancy_o;

    modport master (
        output flush_i, valid_i, instr_i, pc_i, ready_i,
        input  ready_o, valid_o, instr_o, pc_o, imm_o, occupancy_o
    );

    modport slave (
        input  flush_i, valid_i, instr_i, pc_i, ready_i,
        output ready_o, valid_o, instr_o, pc_o, imm_o, occupancy_o
    );
endinterface

// File: rtl/id_decode_queue.sv
// rtl/id_decode_queue.sv - elastic IF->ID queue storing {pc, instr, imm} per entry
// Optional same-cycle pass-through when empty: define IDQ_BYPASS_EN.
module id_decode_queue #(
    parameter int DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    id_decode_queue_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_ALU_I   = 7'b0010011;
    localparam logic [6:0] OP_ALU_I_W = 7'b0011011;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

    function automatic logic [63:0] gen_imm(input logic [31:0] ins);
        logic [63:0] imm;
        logic [2:0]  funct3;
        funct3 = ins[14:12];
        imm    = '0;
        case (ins[6:0])
            OP_LUI, OP_AUIPC: imm = {{32{ins[31]}}, ins[31:12], 12'b0};
            OP_JAL:           imm = {{44{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            OP_JALR, OP_LOAD: imm = {{52{ins[31]}}, ins[31:20]};
            OP_BRANCH:        imm = {{52{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            OP_STORE:         imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
            OP_ALU_I: begin
                // Shift forms keep only shamt (plus bit 26) so funct6 never leaks in.
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    imm = {57'b0, ins[26:20]};
                else
                    imm = {{52{ins[31]}}, ins[31:20]};
            end
            OP_ALU_I_W: begin
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    imm = {59'b0, ins[24:20]};
                else
                    imm = {{52{ins[31]}}, ins[31:20]};
            end
            OP_SYSTEM: begin
                if (funct3 != 3'b100)
                    imm = {{52{ins[31]}}, ins[31:20]};
            end
            default: imm = '0;
        endcase
        return imm;
    endfunction

    logic [31:0]      mem_instr_q [DEPTH];
    logic [63:0]      mem_pc_q    [DEPTH];
    logic [63:0]      mem_imm_q   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        push, push_st, pop_st, bypass, head_valid;
    logic [63:0] imm_in;

    assign imm_in     = gen_imm(bus.instr_i);
    assign head_valid = (count_q != '0);
    assign bus.ready_o = (count_q != CNT_W'(DEPTH));

`ifdef IDQ_BYPASS_EN
    assign bypass = !head_valid && bus.valid_i && !bus.flush_i;
`else
    assign bypass = 1'b0;
`endif

    assign push    = bus.valid_i && bus.ready_o;
    assign push_st = push && !(bypass && bus.ready_i) && !bus.flush_i;
    assign pop_st  = head_valid && bus.ready_i && !bus.flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_st) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_st)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_st, pop_st})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_q[i] <= '0;
                mem_pc_q[i]    <= '0;
                mem_imm_q[i]   <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_st) begin
                mem_instr_q[wr_ptr_q] <= bus.instr_i;
                mem_pc_q[wr_ptr_q]    <= bus.pc_i;
                mem_imm_q[wr_ptr_q]   <= imm_in;
            end
        end
    end

    always_comb begin
        bus.valid_o     = head_valid;
        bus.instr_o     = '0;
        bus.pc_o        = '0;
        bus.imm_o       = '0;
        bus.occupancy_o = count_q;
        if (head_valid) begin
            bus.instr_o = mem_instr_q[rd_ptr_q];
            bus.pc_o    = mem_pc_q[rd_ptr_q];
            bus.imm_o   = mem_imm_q[rd_ptr_q];
        end else if (bypass) begin
            bus.valid_o = 1'b1;
            bus.instr_o = bus.instr_i;
            bus.pc_o    = bus.pc_i;
            bus.imm_o   = imm_in;
        end
    end
endmodule

// File: tb/tb_id_decode_queue.sv
// tb/tb_id_decode_queue.sv - directed table-driven bench for id_decode_queue (DEPTH=2)
module tb_id_decode_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_decode_queue_if #(.DEPTH(2)) bus ();
    id_decode_queue #(.DEPTH(2)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    typedef struct {
        logic        flush, valid, ready;
        logic [31:0] instr;
        logic [63:0] pc;
        logic        e_valid, e_ready;
        logic [1:0]  e_occ;
        logic [31:0] e_instr;
        logic [63:0] e_pc, e_imm;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    localparam int NI = 14;
    logic [31:0] ins_tab [NI] = '{
        32'hFFF00093, 32'h123450B7, 32'h0080006F, 32'h03F09093, 32'hFFFFF297,
        32'h7FF08067, 32'hFF813083, 32'hFE000EE3, 32'h00113823, 32'h4210D093,
        32'h01F0909B, 32'hFFE0809B, 32'h300110F3, 32'h002080B3};
    logic [63:0] imm_tab [NI] = '{
        64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_1234_5000, 64'h8, 64'h3F,
        64'hFFFF_FFFF_FFFF_F000, 64'h7FF, 64'hFFFF_FFFF_FFFF_FFF8,
        64'hFFFF_FFFF_FFFF_FFFC, 64'h10, 64'h21, 64'h1F,
        64'hFFFF_FFFF_FFFF_FFFE, 64'h300, 64'h0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic v, input logic rd,
                         input logic [31:0] ins, input logic [63:0] pc);
        bus.flush_i = fl;
        bus.valid_i = v;
        bus.ready_i = rd;
        bus.instr_i = ins;
        bus.pc_i    = pc;
    endtask

    task automatic check_out(input string tag, input logic v, input logic r, input logic [1:0] occ,
                             input logic [31:0] ins, input logic [63:0] pc, input logic [63:0] imm);
        chk({tag, " valid_o"}, 64'(bus.valid_o), 64'(v));
        chk({tag, " ready_o"}, 64'(bus.ready_o), 64'(r));
        chk({tag, " occupancy_o"}, 64'(bus.occupancy_o), 64'(occ));
        chk({tag, " instr_o"}, 64'(bus.instr_o), 64'(ins));
        chk({tag, " pc_o"}, bus.pc_o, pc);
        chk({tag, " imm_o"}, bus.imm_o, imm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic fl, input logic v, input logic rd, input logic [31:0] ins,
                       input logic [63:0] pc, input logic ev, input logic [1:0] eocc,
                       input logic [31:0] eins, input logic [63:0] epc, input logic [63:0] eimm);
        vec_t t;
        t.flush = fl; t.valid = v; t.ready = rd; t.instr = ins; t.pc = pc;
        t.e_valid = ev; t.e_ready = 1'b1; t.e_occ = eocc;
        t.e_instr = eins; t.e_pc = epc; t.e_imm = eimm;
        vecs.push_back(t);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);

        // Stream: each row pushes one instruction; head shows the previous one.
        add(0, 0, 0, 32'h0, 64'h0, 0, 2'd0, 32'h0, 64'h0, 64'h0);
        for (int k = 0; k < NI; k++) begin
            if (k == 0)
                add(0, 1, 1, ins_tab[k], 64'h8000_0000 + 64'(4 * k), 0, 2'd0, 32'h0, 64'h0, 64'h0);
            else
                add(0, 1, 1, ins_tab[k], 64'h8000_0000 + 64'(4 * k), 1, 2'd1,
                    ins_tab[k-1], 64'h8000_0000 + 64'(4 * (k - 1)), imm_tab[k-1]);
        end
        add(0, 0, 1, 32'h0, 64'h0, 1, 2'd1, ins_tab[NI-1],
            64'h8000_0000 + 64'(4 * (NI - 1)), imm_tab[NI-1]);
        add(0, 0, 1, 32'h0, 64'h0, 0, 2'd0, 32'h0, 64'h0, 64'h0);

        // Reset values while held in reset
        step();
        step();
        @(negedge clk);
        check_out("reset", 1'b0, 1'b1, 2'd0, 32'h0, 64'h0, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifndef IDQ_BYPASS_EN
        foreach (vecs[i]) begin
            drive(vecs[i].flush, vecs[i].valid, vecs[i].ready, vecs[i].instr, vecs[i].pc);
            @(negedge clk);
            check_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_ready, vecs[i].e_occ,
                      vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_imm);
            step();
        end

        // Fill to full, refuse third push even while popping
        drive(0, 1, 0, 32'h00100093, 64'h100);
        step();
        drive(0, 1, 0, 32'h00200113, 64'h104);
        step();
        drive(0, 1, 0, 32'h00300193, 64'h108);
        @(negedge clk);
        check_out("full", 1'b1, 1'b0, 2'd2, 32'h00100093, 64'h100, 64'h1);
        step();
        @(negedge clk);
        check_out("full_stall", 1'b1, 1'b0, 2'd2, 32'h00100093, 64'h100, 64'h1);
        drive(0, 1, 1, 32'h00300193, 64'h108);
        step();
        drive(0, 0, 1, 32'h0, 64'h0);
        @(negedge clk);
        check_out("pop_a", 1'b1, 1'b1, 2'd1, 32'h00200113, 64'h104, 64'h2);
        step();
        @(negedge clk);
        check_out("pop_b", 1'b0, 1'b1, 2'd0, 32'h0, 64'h0, 64'h0);
        step();

        // Flush with same-cycle push and pop
        drive(0, 1, 0, 32'h00100093, 64'h200);
        step();
        drive(1, 1, 1, 32'h00700393, 64'h204);
        @(negedge clk);
        chk("preflush occupancy_o", 64'(bus.occupancy_o), 64'd1);
        step();
        drive(0, 0, 1, 32'h0, 64'h0);
        @(negedge clk);
        check_out("flush", 1'b0, 1'b1, 2'd0, 32'h0, 64'h0, 64'h0);
        step();
        @(negedge clk);
        check_out("flush_after", 1'b0, 1'b1, 2'd0, 32'h0, 64'h0, 64'h0);

        // Async reset with queue full, checked before any clock edge
        step();
        drive(0, 1, 0, 32'h00100093, 64'h300);
        step();
        step();
        drive(0, 0, 0, 32'h0, 64'h0);
        @(negedge clk);
        chk("prereset occupancy_o", 64'(bus.occupancy_o), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 1'b1, 2'd0, 32'h0, 64'h0, 64'h0);
        step();
        rst = 1'b0;
`else
        drive(0, 1, 1, 32'h00500113, 64'h400);
        #1;
        check_out("bypass", 1'b1, 1'b1, 2'd0, 32'h00500113, 64'h400, 64'h5);
        step();
        drive(0, 0, 1, 32'h0, 64'h0);
        @(negedge clk);
        check_out("bypass_after", 1'b0, 1'b1, 2'd0, 32'h0, 64'h0, 64'h0);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
